alu_stream: RTL and testbench

ALU_STREAM -- requirements
Module: alu_stream

---
 rtl/alu_stream.sv | 222 ++++++++++++++++++++++
 tb/tb_alu_stream.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_stream.sv
// Streaming ALU: collects operands, folds them into an accumulator (echo/add/multiply/divide)
// and streams the DATA_W-bit result out a byte at a time. Divide exists only with ALU_STREAM_DIV_EN.
module alu_stream #(
    parameter int DATA_W         = 32,
    parameter bit BYTE_LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        opcode_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] operand_i,
    input  logic              operand_valid_i,
    input  logic              operand_last_i,
    output logic              operand_ready_o,
    output logic [7:0]        byte_o,
    output logic              byte_valid_o,
    input  logic              byte_ready_i,
    output logic              busy_o,
    output logic              error_o
);

    localparam int NBYTES = DATA_W / 8;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [7:0] OP_ECHO = 8'hEC;
    localparam logic [7:0] OP_ADD  = 8'hAD;
    localparam logic [7:0] OP_MUL  = 8'hAC;
`ifdef ALU_STREAM_DIV_EN
    localparam logic [7:0] OP_DIV  = 8'hD1;
    localparam int         CNT_W   = $clog2(DATA_W);
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DIVIDE  = 2'd2,
        EMIT    = 2'd3
    } state_t;

    state_t            state, state_next;
    logic [7:0]        op_q;
    logic [DATA_W-1:0] acc;
    logic              got_first;
    logic              last_q;
    logic [IDX_W-1:0]  byte_idx;
    logic              error_q;

    logic              op_fire;
    logic              byte_fire;
    logic              last_byte;
    logic              start_ok;
    logic [IDX_W-1:0]  shift_idx;
    logic [DATA_W-1:0] emit_word;

`ifdef ALU_STREAM_DIV_EN
    logic [DATA_W-1:0] div_rem;
    logic [DATA_W-1:0] div_quo;
    logic [DATA_W-1:0] div_dvsr;
    logic [CNT_W-1:0]  div_cnt;
    logic [DATA_W:0]   div_shift;
    logic [DATA_W:0]   div_diff;
    logic              div_ge;
    logic [DATA_W-1:0] rem_next;
    logic [DATA_W-1:0] quo_next;
`endif

    function automatic logic op_supported(input logic [7:0] op);
        logic ok;
        ok = (op == OP_ECHO) || (op == OP_ADD) || (op == OP_MUL);
`ifdef ALU_STREAM_DIV_EN
        ok = ok || (op == OP_DIV);
`endif
        return ok;
    endfunction

    assign operand_ready_o = (state == COLLECT);
    assign byte_valid_o    = (state == EMIT);
    assign busy_o          = (state != IDLE);
    assign error_o         = error_q;

    assign op_fire   = operand_valid_i && operand_ready_o;
    assign byte_fire = byte_valid_o && byte_ready_i;
    assign last_byte = (byte_idx == IDX_W'(NBYTES - 1));
    assign start_ok  = (state == IDLE) && start_i && op_supported(opcode_i);

    // Byte lane selection: the index counts transfers, the order parameter maps it to a lane.
    always_comb begin
        shift_idx = BYTE_LSB_FIRST ? byte_idx : (IDX_W'(NBYTES - 1) - byte_idx);
        emit_word = acc >> {shift_idx, 3'b000};
        byte_o    = (state == EMIT) ? emit_word[7:0] : 8'h00;
    end

`ifdef ALU_STREAM_DIV_EN
    // One restoring step; a zero divisor always "fits", which yields an all-ones quotient.
    always_comb begin
        div_shift = {div_rem, div_quo[DATA_W-1]};
        div_diff  = div_shift - {1'b0, div_dvsr};
        div_ge    = (div_shift >= {1'b0, div_dvsr});
        rem_next  = div_ge ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0];
        quo_next  = {div_quo[DATA_W-2:0], div_ge};
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                if (op_fire) begin
                    if (op_q == OP_ECHO) begin
                        state_next = EMIT;
`ifdef ALU_STREAM_DIV_EN
                    end else if ((op_q == OP_DIV) && got_first) begin
                        state_next = DIVIDE;
`endif
                    end else if (operand_last_i) begin
                        state_next = EMIT;
                    end
                end
            end
`ifdef ALU_STREAM_DIV_EN
            DIVIDE: begin
                if (div_cnt == '0) begin
                    state_next = last_q ? EMIT : COLLECT;
                end
            end
`endif
            EMIT: begin
                if (byte_fire && last_byte) begin
                    state_next = ((op_q == OP_ECHO) && !last_q) ? COLLECT : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= 8'h00;
            acc       <= '0;
            got_first <= 1'b0;
            last_q    <= 1'b0;
            byte_idx  <= '0;
            error_q   <= 1'b0;
`ifdef ALU_STREAM_DIV_EN
            div_rem   <= '0;
            div_quo   <= '0;
            div_dvsr  <= '0;
            div_cnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        if (op_supported(opcode_i)) begin
                            op_q      <= opcode_i;
                            error_q   <= 1'b0;
                            got_first <= 1'b0;
                            last_q    <= 1'b0;
                            byte_idx  <= '0;
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (op_fire) begin
                        got_first <= 1'b1;
                        last_q    <= operand_last_i;
                        byte_idx  <= '0;
                        if ((op_q == OP_ECHO) || !got_first) begin
                            acc <= operand_i;
                        end else if (op_q == OP_ADD) begin
                            acc <= acc + operand_i;
                        end else if (op_q == OP_MUL) begin
                            acc <= acc * operand_i;
`ifdef ALU_STREAM_DIV_EN
                        end else if (op_q == OP_DIV) begin
                            div_rem  <= '0;
                            div_quo  <= acc;
                            div_dvsr <= operand_i;
                            div_cnt  <= CNT_W'(DATA_W - 1);
                            if (operand_i == '0) begin
                                error_q <= 1'b1;
                            end
`endif
                        end
                    end
                end
`ifdef ALU_STREAM_DIV_EN
                DIVIDE: begin
                    div_rem <= rem_next;
                    div_quo <= quo_next;
                    div_cnt <= div_cnt - 1'b1;
                    if (div_cnt == '0) begin
                        acc <= quo_next;
                    end
                end
`endif
                EMIT: begin
                    if (byte_fire) begin
                        byte_idx <= last_byte ? '0 : (byte_idx + 1'b1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_stream.sv
// Directed bench for alu_stream (DATA_W=32, LSB first); divide checks depend on ALU_STREAM_DIV_EN.
module tb_alu_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  opcode_i = 8'h00;
    logic        start_i = 1'b0;
    logic [31:0] operand_i = 32'h0;
    logic        operand_valid_i = 1'b0;
    logic        operand_last_i = 1'b0;
    logic        operand_ready_o;
    logic [7:0]  byte_o;
    logic        byte_valid_o;
    logic        byte_ready_i = 1'b0;
    logic        busy_o;
    logic        error_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_stream #(.DATA_W(32), .BYTE_LSB_FIRST(1'b1)) dut (
        .clk(clk),
        .rst(rst),
        .opcode_i(opcode_i),
        .start_i(start_i),
        .operand_i(operand_i),
        .operand_valid_i(operand_valid_i),
        .operand_last_i(operand_last_i),
        .operand_ready_o(operand_ready_o),
        .byte_o(byte_o),
        .byte_valid_o(byte_valid_o),
        .byte_ready_i(byte_ready_i),
        .busy_o(busy_o),
        .error_o(error_o)
    );

    task automatic do_start(input logic [7:0] op);
        @(negedge clk);
        opcode_i = op;
        start_i  = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic send_operand(input logic [31:0] d, input bit last, output bit ok);
        int cyc;
        cyc = 0;
        @(negedge clk);
        operand_i       = d;
        operand_last_i  = last;
        operand_valid_i = 1'b1;
        while (!operand_ready_o && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        ok = operand_ready_o;
        @(posedge clk);
        #1;
        operand_valid_i = 1'b0;
        operand_last_i  = 1'b0;
    endtask

    // First byte received lands in got[7:0]; stability is tracked across stalled cycles.
    task automatic collect_bytes(input int n, input bit stall, output logic [63:0] got,
                                 output int n_got, output int unstable);
        int cyc;
        bit prev_stall;
        logic [7:0] prev_byte;
        got = 64'h0; n_got = 0; unstable = 0; prev_stall = 1'b0; prev_byte = 8'h00; cyc = 0;
        while (n_got < n && cyc < 200) begin
            byte_ready_i = stall ? cyc[0] : 1'b1;
            @(negedge clk);
            if (prev_stall && byte_valid_o && (byte_o !== prev_byte)) unstable++;
            prev_stall = byte_valid_o && !byte_ready_i;
            prev_byte  = byte_o;
            if (byte_valid_o && byte_ready_i) begin
                got[n_got*8 +: 8] = byte_o;
                n_got++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        byte_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        operand_valid_i = 1'b1;
        operand_i       = 32'hDEAD_BEEF;
        start_i         = 1'b1;
        opcode_i        = 8'hAD;
        byte_ready_i    = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        n_checks++; if (operand_ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ready: got %b expected 0", operand_ready_o); end
        n_checks++; if (byte_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_byte_valid: got %b expected 0", byte_valid_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_o); end
        n_checks++; if (error_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_error: got %b expected 0", error_o); end
        n_checks++; if (byte_o !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_byte: got %h expected 00", byte_o); end
        @(negedge clk);
        start_i      = 1'b0;
        byte_ready_i = 1'b0;
        rst          = 1'b0;
        // operand offered in IDLE must be ignored
        repeat (2) @(negedge clk);
        n_checks++; if (operand_ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_ready: got %b expected 0", operand_ready_o); end
        operand_valid_i = 1'b0;
    endtask

    task automatic test_bad_opcode();
        do_start(8'h55);
        n_checks++; if (error_o !== 1'b1) begin n_fail++; $display("[TB] FAIL badop_error: got %b expected 1", error_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL badop_busy: got %b expected 0", busy_o); end
    endtask

    task automatic test_add();
        logic [63:0] got; int n_got, unstable; bit ok, all_ok;
        do_start(8'hAD);
        n_checks++; if (error_o !== 1'b0) begin n_fail++; $display("[TB] FAIL add_error_clear: got %b expected 0", error_o); end
        send_operand(32'hFFFF_FFFF, 1'b0, ok); all_ok = ok;
        // start while busy must neither restart nor flag an error
        do_start(8'h55);
        send_operand(32'h0000_0002, 1'b1, ok); all_ok &= ok;
        n_checks++; if (all_ok !== 1'b1) begin n_fail++; $display("[TB] FAIL add_handshake: got %b expected 1", all_ok); end
        n_checks++; if (byte_valid_o !== 1'b1) begin n_fail++; $display("[TB] FAIL add_latency: byte_valid %b expected 1", byte_valid_o); end
        collect_bytes(4, 1'b0, got, n_got, unstable);
        n_checks++; if (n_got !== 4) begin n_fail++; $display("[TB] FAIL add_count: got %0d expected 4", n_got); end
        n_checks++; if (got[31:0] !== 32'h0000_0001) begin n_fail++; $display("[TB] FAIL add_bytes: got %h expected 00000001", got[31:0]); end
        n_checks++; if (error_o !== 1'b0) begin n_fail++; $display("[TB] FAIL add_error: got %b expected 0", error_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL add_done_busy: got %b expected 0", busy_o); end
    endtask

    task automatic test_multiply_stall();
        logic [63:0] got; int n_got, unstable; bit ok, all_ok;
        do_start(8'hAC);
        send_operand(32'd3, 1'b0, ok); all_ok = ok;
        send_operand(32'd5, 1'b0, ok); all_ok &= ok;
        send_operand(32'd7, 1'b1, ok); all_ok &= ok;
        n_checks++; if (all_ok !== 1'b1) begin n_fail++; $display("[TB] FAIL mul_handshake: got %b expected 1", all_ok); end
        collect_bytes(4, 1'b1, got, n_got, unstable);
        n_checks++; if (got[31:0] !== 32'h0000_0069) begin n_fail++; $display("[TB] FAIL mul_bytes: got %h expected 00000069", got[31:0]); end
        n_checks++; if (unstable !== 0) begin n_fail++; $display("[TB] FAIL mul_stall_stable: got %0d changes expected 0", unstable); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL mul_done_busy: got %b expected 0", busy_o); end
    endtask

    task automatic test_single_operand();
        logic [63:0] got; int n_got, unstable; bit ok;
        do_start(8'hAC);
        send_operand(32'h1234_5678, 1'b1, ok);
        collect_bytes(4, 1'b0, got, n_got, unstable);
        n_checks++; if (got[31:0] !== 32'h1234_5678) begin n_fail++; $display("[TB] FAIL single_bytes: got %h expected 12345678", got[31:0]); end
    endtask

    task automatic test_echo();
        logic [63:0] got, got2; int n_got, unstable; bit ok;
        do_start(8'hEC);
        send_operand(32'h1122_3344, 1'b0, ok);
        collect_bytes(4, 1'b0, got, n_got, unstable);
        n_checks++; if (operand_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL echo_back_to_collect: got %b expected 1", operand_ready_o); end
        send_operand(32'hAABB_CCDD, 1'b1, ok);
        collect_bytes(4, 1'b0, got2, n_got, unstable);
        got[63:32] = got2[31:0];
        n_checks++; if (got !== 64'hAABB_CCDD_1122_3344) begin n_fail++; $display("[TB] FAIL echo_bytes: got %h expected aabbccdd11223344", got); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL echo_idle: busy %b expected 0", busy_o); end
    endtask

`ifdef ALU_STREAM_DIV_EN
    task automatic test_divide();
        logic [63:0] got; int n_got, unstable, cnt; bit ok, ready_low;
        do_start(8'hD1);
        send_operand(32'd100, 1'b0, ok);
        send_operand(32'd7, 1'b1, ok);
        cnt = 0; ready_low = 1'b1;
        while (!byte_valid_o && cnt < 100) begin
            if (operand_ready_o) ready_low = 1'b0;
            @(posedge clk); #1; cnt++;
        end
        n_checks++; if (cnt !== 32) begin n_fail++; $display("[TB] FAIL div_cycles: got %0d expected 32", cnt); end
        n_checks++; if (ready_low !== 1'b1) begin n_fail++; $display("[TB] FAIL div_ready_low: got %b expected 1", ready_low); end
        collect_bytes(4, 1'b0, got, n_got, unstable);
        n_checks++; if (got[31:0] !== 32'h0000_000E) begin n_fail++; $display("[TB] FAIL div_bytes: got %h expected 0000000e", got[31:0]); end
        do_start(8'hD1);
        send_operand(32'd5, 1'b0, ok);
        send_operand(32'd0, 1'b1, ok);
        cnt = 0;
        while (!byte_valid_o && cnt < 100) begin
            @(posedge clk); #1; cnt++;
        end
        n_checks++; if (cnt !== 32) begin n_fail++; $display("[TB] FAIL div0_cycles: got %0d expected 32", cnt); end
        collect_bytes(4, 1'b0, got, n_got, unstable);
        n_checks++; if (got[31:0] !== 32'hFFFF_FFFF) begin n_fail++; $display("[TB] FAIL div0_bytes: got %h expected ffffffff", got[31:0]); end
        n_checks++; if (error_o !== 1'b1) begin n_fail++; $display("[TB] FAIL div0_error: got %b expected 1", error_o); end
    endtask
`else
    task automatic test_div_disabled();
        do_start(8'hD1);
        n_checks++; if (error_o !== 1'b1) begin n_fail++; $display("[TB] FAIL nodiv_error: got %b expected 1", error_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL nodiv_busy: got %b expected 0", busy_o); end
        @(posedge clk); #1;
        n_checks++; if (operand_ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL nodiv_ready: got %b expected 0", operand_ready_o); end
    endtask
`endif

    task automatic test_reset_mid_emit();
        bit ok; int extra;
        do_start(8'hAD);
        send_operand(32'h0000_0010, 1'b0, ok);
        send_operand(32'h0000_0020, 1'b1, ok);
        byte_ready_i = 1'b1;
        @(posedge clk); #1;
        byte_ready_i = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        n_checks++; if (byte_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_valid: got %b expected 0", byte_valid_o); end
        n_checks++; if (byte_o !== 8'h00) begin n_fail++; $display("[TB] FAIL rstmid_byte: got %h expected 00", byte_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_busy: got %b expected 0", busy_o); end
        @(negedge clk);
        rst = 1'b0;
        byte_ready_i = 1'b1;
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (byte_valid_o) extra++;
        end
        byte_ready_i = 1'b0;
        n_checks++; if (extra !== 0) begin n_fail++; $display("[TB] FAIL rstmid_no_bytes: got %0d bytes expected 0", extra); end
    endtask

    initial begin
        test_reset();
        test_bad_opcode();
        test_add();
        test_multiply_stall();
        test_single_operand();
        test_echo();
`ifdef ALU_STREAM_DIV_EN
        test_divide();
`else
        test_div_disabled();
`endif
        test_reset_mid_emit();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
